// File: rtl/banked_mem_model_if.sv
// Request/response bundle between the cache controller's memory port and the banked memory.
interface banked_mem_model_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  modport master (
    output Addr, DataIn, Rd, Wr,
    input  DataOut, stall, busy, err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr,
    output DataOut, stall, busy, err
  );
endinterface

// File: rtl/banked_mem_model.sv
// Four-bank word memory: bank = Addr[2:1], fixed per-bank occupancy, two-cycle read latency.
module banked_mem_model #(
  parameter int WORDS       = 32768,
  parameter int BUSY_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  banked_mem_model_if.slave bus
);
  localparam int         AW   = $clog2(WORDS);
  localparam logic [2:0] LOAD = 3'(BUSY_CYCLES - 1);

  logic          req;
  logic          malformed;
  logic          stall;
  logic          accept;
  logic [1:0]    bank;
  logic [AW-1:0] idx;
  logic [2:0]    cnt      [4];
  logic [2:0]    cnt_next [4];
  logic [3:0]    busy_q;
  logic          rd_valid;
  logic [AW-1:0] rd_idx;
  logic [15:0]   data_q;

  // Zero contents at time 0 model the power-up image; rst never clears them.
  logic [15:0]   mem [WORDS] = '{default: 16'h0000};

  assign req       = bus.Rd | bus.Wr;
  assign malformed = (bus.Rd & bus.Wr) | (req & bus.Addr[0]);
  assign bank      = bus.Addr[2:1];
  assign idx       = AW'(bus.Addr[15:1]);
  assign stall     = req & ~malformed & busy_q[bank];
  assign accept    = req & ~malformed & ~stall;

  assign bus.err     = malformed;
  assign bus.stall   = stall;
  assign bus.busy    = busy_q;
  assign bus.DataOut = data_q;

  // Next occupancy count per bank: reload on accept, otherwise run down to zero.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      if (accept && (bank == 2'(b))) begin
        cnt_next[b] = LOAD;
      end else if (cnt[b] != 3'd0) begin
        cnt_next[b] = cnt[b] - 3'd1;
      end else begin
        cnt_next[b] = cnt[b];
      end
    end
  end

  // Occupancy counters and the registered busy flags derived from them.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (rst) begin
        cnt[b]    <= 3'd0;
        busy_q[b] <= 1'b0;
      end else begin
        cnt[b]    <= cnt_next[b];
        busy_q[b] <= (cnt_next[b] != 3'd0);
      end
    end
  end

  // Storage write; a write coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (accept && bus.Wr && !rst) begin
      mem[idx] <= bus.DataIn;
    end
  end

  // Read pipeline: stage 1 holds the accepted index, stage 2 is the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      data_q   <= 16'h0000;
    end else begin
      rd_valid <= accept & bus.Rd;
      rd_idx   <= idx;
      data_q   <= rd_valid ? mem[rd_idx] : 16'h0000;
    end
  end
endmodule

// File: tb/tb_banked_mem_model.sv
// Directed bench for banked_mem_model: default instance plus a WORDS=16 instance for wrap.
module tb_banked_mem_model;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  banked_mem_model_if bus_a ();
  banked_mem_model_if bus_b ();

  banked_mem_model #(.WORDS(32768), .BUSY_CYCLES(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  banked_mem_model #(.WORDS(16),    .BUSY_CYCLES(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 after the edge, checks happen 2 after the edge (same cycle).
  task automatic cyc_a(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] din);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus_a.Rd     = rd;
    bus_a.Wr     = wr;
    bus_a.Addr   = addr;
    bus_a.DataIn = din;
    #1;
  endtask

  task automatic cyc_b(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] din);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus_b.Rd     = rd;
    bus_b.Wr     = wr;
    bus_b.Addr   = addr;
    bus_b.DataIn = din;
    #1;
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) cyc_a(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    bus_a.Rd = 1'b0; bus_a.Wr = 1'b0; bus_a.Addr = 16'h0000; bus_a.DataIn = 16'h0000;
    bus_b.Rd = 1'b0; bus_b.Wr = 1'b0; bus_b.Addr = 16'h0000; bus_b.DataIn = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_dataout", bus_a.DataOut, 16'h0000);
    chk("reset_busy",    {12'h000, bus_a.busy}, 16'h0000);
    chk("reset_stall",   {15'h0000, bus_a.stall}, 16'h0000);
    chk("reset_err",     {15'h0000, bus_a.err}, 16'h0000);

    // Write then read back the same word once the bank is free again.
    cyc_a(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("wr_stall", {15'h0000, bus_a.stall}, 16'h0000);
    chk("wr_busy_t0", {12'h000, bus_a.busy}, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      cyc_a(1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("wr_busy_held", {12'h000, bus_a.busy}, 16'h0001);
    end
    cyc_a(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("rd_busy_free", {12'h000, bus_a.busy}, 16'h0000);
    chk("rd_stall", {15'h0000, bus_a.stall}, 16'h0000);
    cyc_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("rd_t5_dataout", bus_a.DataOut, 16'h0000);
    cyc_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("rd_t6_dataout", bus_a.DataOut, 16'hBEEF);
    cyc_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("rd_t7_dataout", bus_a.DataOut, 16'h0000);

    // Burst across all four banks.
    cyc_a(1'b0, 1'b1, 16'h0100, 16'h0001);
    cyc_a(1'b0, 1'b1, 16'h0102, 16'h0002);
    cyc_a(1'b0, 1'b1, 16'h0104, 16'h0003);
    cyc_a(1'b0, 1'b1, 16'h0106, 16'h0004);
    idle_a(4);
    cyc_a(1'b1, 1'b0, 16'h0100, 16'h0000);
    chk("burst_stall0", {15'h0000, bus_a.stall}, 16'h0000);
    cyc_a(1'b1, 1'b0, 16'h0102, 16'h0000);
    chk("burst_stall1", {15'h0000, bus_a.stall}, 16'h0000);
    cyc_a(1'b1, 1'b0, 16'h0104, 16'h0000);
    chk("burst_stall2", {15'h0000, bus_a.stall}, 16'h0000);
    chk("burst_data1", bus_a.DataOut, 16'h0001);
    cyc_a(1'b1, 1'b0, 16'h0106, 16'h0000);
    chk("burst_stall3", {15'h0000, bus_a.stall}, 16'h0000);
    chk("burst_data2", bus_a.DataOut, 16'h0002);
    // Bank 3 (accepted this cycle) is only occupied from the next cycle on.
    chk("burst_busy_t3", {12'h000, bus_a.busy}, 16'h0007);
    cyc_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("burst_data3", bus_a.DataOut, 16'h0003);
    chk("burst_busy_t4", {12'h000, bus_a.busy}, 16'h000E);
    cyc_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("burst_data4", bus_a.DataOut, 16'h0004);
    cyc_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("burst_data_end", bus_a.DataOut, 16'h0000);

    // Same-bank conflict: second read stalls three cycles then goes.
    idle_a(4);
    cyc_a(1'b0, 1'b1, 16'h0000, 16'h1111);
    idle_a(3);
    cyc_a(1'b0, 1'b1, 16'h0008, 16'h2222);
    idle_a(4);
    cyc_a(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("conf_first_stall", {15'h0000, bus_a.stall}, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      cyc_a(1'b1, 1'b0, 16'h0008, 16'h0000);
      chk("conf_stall", {15'h0000, bus_a.stall}, 16'h0001);
      if (i == 2) chk("conf_first_data", bus_a.DataOut, 16'h1111);
      else        chk("conf_gap_data", bus_a.DataOut, 16'h0000);
    end
    cyc_a(1'b1, 1'b0, 16'h0008, 16'h0000);
    chk("conf_accept", {15'h0000, bus_a.stall}, 16'h0000);
    cyc_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("conf_t5_data", bus_a.DataOut, 16'h0000);
    cyc_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("conf_t6_data", bus_a.DataOut, 16'h2222);

    // Malformed requests: flagged, never accepted, no side effects.
    idle_a(4);
    cyc_a(1'b1, 1'b1, 16'h0020, 16'hFFFF);
    chk("err_rdwr", {15'h0000, bus_a.err}, 16'h0001);
    chk("err_rdwr_stall", {15'h0000, bus_a.stall}, 16'h0000);
    cyc_a(1'b1, 1'b0, 16'h0021, 16'h0000);
    chk("err_odd_rd", {15'h0000, bus_a.err}, 16'h0001);
    chk("err_busy", {12'h000, bus_a.busy}, 16'h0000);
    cyc_a(1'b0, 1'b1, 16'h0021, 16'hAAAA);
    chk("err_odd_wr", {15'h0000, bus_a.err}, 16'h0001);
    chk("err_data1", bus_a.DataOut, 16'h0000);
    cyc_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("err_busy_after", {12'h000, bus_a.busy}, 16'h0000);
    chk("err_data2", bus_a.DataOut, 16'h0000);
    cyc_a(1'b1, 1'b0, 16'h0020, 16'h0000);
    idle_a(2);
    chk("err_mem_unchanged", bus_a.DataOut, 16'h0000);

    // Reset mid-flight: drops the read, frees banks, discards a write.
    idle_a(4);
    cyc_a(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus_a.Rd = 1'b0; bus_a.Wr = 1'b1; bus_a.Addr = 16'h0032; bus_a.DataIn = 16'h5555;
    #1;
    cyc_a(1'b0, 1'b1, 16'h0010, 16'h7777);
    chk("rst_dataout", bus_a.DataOut, 16'h0000);
    chk("rst_busy", {12'h000, bus_a.busy}, 16'h0000);
    chk("rst_wr_stall", {15'h0000, bus_a.stall}, 16'h0000);
    cyc_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("rst_wr_busy", {12'h000, bus_a.busy}, 16'h0001);
    chk("rst_dataout2", bus_a.DataOut, 16'h0000);
    idle_a(4);
    cyc_a(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle_a(2);
    chk("rst_post_write", bus_a.DataOut, 16'h7777);
    idle_a(4);
    cyc_a(1'b1, 1'b0, 16'h0032, 16'h0000);
    idle_a(2);
    chk("rst_write_dropped", bus_a.DataOut, 16'h0000);

    // Wrap on the 16-word instance: 0x0022 aliases word 1 (0x0002).
    cyc_b(1'b0, 1'b1, 16'h0022, 16'h1234);
    chk("wrap_wr_err", {15'h0000, bus_b.err}, 16'h0000);
    for (int i = 0; i < 4; i++) cyc_b(1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc_b(1'b1, 1'b0, 16'h0002, 16'h0000);
    chk("wrap_rd_stall", {15'h0000, bus_b.stall}, 16'h0000);
    cyc_b(1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc_b(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("wrap_data", bus_b.DataOut, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
